cur_sel_dwa: RTL and testbench
==============================

# cur_sel_dwa

Parametrised current-DAC cell selector, successor to the 4-bit static current decoder in the NNSENSE current-select path. It converts an NBITS-bit current code into enables for 2^NBITS unit current cells. It adds registered outputs, a load strobe, and four modes:

- static thermometer
- static one-hot
- data-weighted-averaging (DWA) rotation, for cell-mismatch shaping
- slew-limited ramp with a busy handshake

It sits between the NNSENSE configuration registers and the unit-cell array.

## Interface
Parameters:
- NBITS, 4, code width; cell count M = 2^NBITS
- STEP, 1, max cells added/removed per clock in ramp mode (1..M-1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- code_in  input  NBITS  requested current code, sampled only on an accepted load
- mode_in  input  2  00 thermometer, 01 one-hot, 10 DWA, 11 ramp; sampled with code_in
- load  input  1  single-cycle request strobe
- sel  output  M  unit-cell enables, registered
- level  output  NBITS  code currently applied to the array
- ptr  output  NBITS  DWA rotation pointer (next start cell)
- busy  output  1  high while a ramp is in progress

## Operation
- Accept rule: load is accepted on a rising clk edge when busy=0. Load while busy=1 is ignored: no state change, no queuing.
- On accept, mode_in is registered as mode_q. mode_q persists until the next accepted load.
- Thermometer (00):
  - level <= code_in
  - sel <= bits [code_in-1:0] set, i.e. (1<<code_in)-1
  - ptr unchanged
- One-hot (01):
  - level <= code_in
  - sel <= 1<<code_in (code 0 drives sel[0])
  - ptr unchanged
- DWA (10):
  - level <= code_in
  - sel <= code_in consecutive ones starting at bit ptr, wrapping modulo M past bit M-1 to bit 0
  - ptr <= (ptr + code_in) mod M
  - code 0: sel=0, ptr unchanged
- Ramp (11):
  - On accept, target <= code_in.
  - If target == level: busy stays 0 and nothing changes.
  - Otherwise busy <= 1. Each subsequent clock, level moves toward target by min(STEP, |target-level|).
  - sel always equals the thermometer pattern of the current level, (1<<level)-1.
  - busy clears on the same edge on which level reaches target.
- Arithmetic: the pointer sum is an NBITS-bit modulo add. The ramp difference is computed as an unsigned NBITS+1-bit magnitude; no overflow past 0 or M-1.
- Leaving DWA for another mode does not alter ptr. Re-entering DWA resumes from the stored ptr.
- Mode switch into ramp: the ramp starts from the current level, whatever mode produced it. sel is re-expressed as a thermometer from the first ramp edge.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert expected upstream) forces:
  - sel=0, level=0, ptr=0, busy=0
  - mode_q=00, target=0
- Reset mid-ramp aborts immediately, with all outputs as above.
- Latency, non-ramp modes: sel, level and ptr update on the edge that accepts load, and are visible one cycle after load is asserted.
- Latency, ramp: busy rises on the accept edge. level changes on each following edge. Total ramp duration after accept is ceil(|target-level0|/STEP) cycles.
- Back-to-back loads in non-ramp modes are accepted every cycle.
- A load on the same edge that busy clears is ignored, because busy=1 before that edge. The earliest next accept is the following edge.
- level, ptr and sel are stable between accepted loads, except during a ramp.

## Test plan
- Reset then thermometer sweep: NBITS=4, mode 00, load codes 0..15 at 10-cycle spacing -> sel=(1<<k)-1 one cycle after each load; level=k; ptr=0; busy=0 throughout.
- One-hot: mode 01, load code 5 -> sel=16'h0020, level=5; load code 0 -> sel=16'h0001.
- DWA wrap: mode 10, from reset load 10, then 9, then 0, then 3:
  - after 10: sel=16'h03FF, ptr=10
  - after 9: sel=16'hFC07 (bits 10..15, 0..2), ptr=3
  - after 0: sel=0, ptr=3
  - after 3: sel=16'h0038, ptr=6
- Ramp with STEP=3, mode 11, level 0, load 11:
  - busy=1 for 4 cycles; level sequence 3, 6, 9, 11; busy clears with level=11
  - a load of code 2 during busy is ignored
  - then load 2 -> level sequence 8, 5, 2
- Reset mid-ramp: assert rst_n=0 during a ramp 0->15 at level 6 -> sel=0, level=0, busy=0 immediately, without waiting for clk; after release, the first load is accepted normally.
- Mode interplay: DWA to ptr=7, thermometer load 4, DWA load 2 -> after the DWA load, sel=16'h0180, ptr=9 (ptr preserved across the mode switch).

Source files
------------

// File: rtl/cur_sel_dwa.sv
`default_nettype none
// ============================================================================
// Module      : cur_sel_dwa
// Description : Current-DAC unit-cell selector. Converts an NBITS-bit code
//               into 2^NBITS registered cell enables using thermometer,
//               one-hot, data-weighted-averaging rotation or a slew-limited
//               ramp with a busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cur_sel_dwa #(
  parameter int NBITS = 4,
  parameter int STEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NBITS-1:0]      code_in,
  input  logic [1:0]            mode_in,
  input  logic                  load,
  output logic [(1<<NBITS)-1:0] sel,
  output logic [NBITS-1:0]      level,
  output logic [NBITS-1:0]      ptr,
  output logic                  busy
);

  localparam int M = 1 << NBITS;

  localparam logic [1:0] MODE_THERM  = 2'b00;
  localparam logic [1:0] MODE_ONEHOT = 2'b01;
  localparam logic [1:0] MODE_DWA    = 2'b10;
  localparam logic [1:0] MODE_RAMP   = 2'b11;

  // Step size widened to the magnitude width so the min() compare is exact.
  localparam logic [NBITS:0] STEP_W = (NBITS+1)'(STEP);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     sel_q, sel_d;
  logic [NBITS-1:0] level_q, level_d;
  logic [NBITS-1:0] ptr_q, ptr_d;
  logic [NBITS-1:0] target_q, target_d;
  logic [1:0]       mode_q, mode_d;

  logic             accept;
  logic [M-1:0]     code_therm;
  logic [2*M-1:0]   dwa_dbl;
  logic [M-1:0]     dwa_rot;
  logic             ramp_up;
  logic [NBITS:0]   ramp_diff;
  logic [NBITS:0]   ramp_step;
  logic [NBITS-1:0] ramp_next;

  // Thermometer pattern: the lowest k cells enabled.
  function automatic logic [M-1:0] therm(input logic [NBITS-1:0] k);
    logic [M-1:0] t;
    t = '0;
    for (int i = 0; i < M; i++) begin
      t[i] = (i < int'(k));
    end
    return t;
  endfunction

  // Decode helpers: rotation of the thermometer by ptr and ramp step size.
  always_comb begin
    accept     = load && (state_q == S_IDLE);
    code_therm = therm(code_in);
    // Shift into a double-width word and fold the overflow back onto the
    // low half; this realises the modulo-M wrap past cell M-1.
    dwa_dbl    = {{M{1'b0}}, code_therm} << ptr_q;
    dwa_rot    = dwa_dbl[M-1:0] | dwa_dbl[2*M-1:M];
    ramp_up    = (target_q > level_q);
    if (ramp_up) begin
      ramp_diff = {1'b0, target_q} - {1'b0, level_q};
    end else begin
      ramp_diff = {1'b0, level_q} - {1'b0, target_q};
    end
    ramp_step  = (ramp_diff < STEP_W) ? ramp_diff : STEP_W;
    // Step never exceeds the remaining distance, so no wrap past 0 or M-1.
    if (ramp_up) begin
      ramp_next = level_q + ramp_step[NBITS-1:0];
    end else begin
      ramp_next = level_q - ramp_step[NBITS-1:0];
    end
  end

  // Next-state and output selection for the accept and ramp paths.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    level_d  = level_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    mode_d   = mode_q;

    if (state_q == S_RAMP) begin
      if (mode_q == MODE_RAMP) begin
        level_d = ramp_next;
        sel_d   = therm(ramp_next);
        if (ramp_next == target_q) begin
          state_d = S_IDLE;
        end
      end else begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      mode_d = mode_in;
      case (mode_in)
        MODE_THERM: begin
          level_d = code_in;
          sel_d   = code_therm;
        end
        MODE_ONEHOT: begin
          level_d = code_in;
          sel_d   = {{(M-1){1'b0}}, 1'b1} << code_in;
        end
        MODE_DWA: begin
          level_d = code_in;
          sel_d   = dwa_rot;
          ptr_d   = ptr_q + code_in;
        end
        default: begin
          target_d = code_in;
          if (code_in != level_q) begin
            state_d = S_RAMP;
            sel_d   = therm(level_q);
          end
        end
      endcase
    end
  end

  // State registers; asynchronous reset also aborts any ramp in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      level_q  <= '0;
      ptr_q    <= '0;
      target_q <= '0;
      mode_q   <= MODE_THERM;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      level_q  <= level_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      mode_q   <= mode_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    sel   = sel_q;
    level = level_q;
    ptr   = ptr_q;
    busy  = (state_q == S_RAMP);
  end

endmodule
`default_nettype wire

// File: tb/tb_cur_sel_dwa.sv
`default_nettype none
// ============================================================================
// Module      : tb_cur_sel_dwa
// Description : Scoreboard bench for cur_sel_dwa (NBITS=4, STEP=3). Stimulus
//               queues hand-computed expectations tagged with the cycle they
//               apply to; a monitor compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cur_sel_dwa;

  localparam int NBITS = 4;
  localparam int STEP  = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  code_in;
  logic [1:0]  mode_in;
  logic        load;
  logic [15:0] sel;
  logic [3:0]  level;
  logic [3:0]  ptr;
  logic        busy;

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] sel;
    logic [3:0]  level;
    logic [3:0]  ptr;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  cur_sel_dwa #(.NBITS(NBITS), .STEP(STEP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .code_in (code_in),
    .mode_in (mode_in),
    .load    (load),
    .sel     (sel),
    .level   (level),
    .ptr     (ptr),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue an expectation for the state dly rising edges from now.
  task automatic expect_at(input int dly, input int id, input logic [15:0] s,
                           input logic [3:0] l, input logic [3:0] p, input logic b);
    exp_t e;
    e.cyc = cyc + dly; e.id = id; e.sel = s; e.level = l; e.ptr = p; e.busy = b;
    sb_q.push_back(e);
  endtask

  // Compare outputs right now (used for the asynchronous reset checks).
  task automatic check_now(input int id, input logic [15:0] s, input logic [3:0] l,
                           input logic [3:0] p, input logic b);
    checks++;
    if (sel !== s || level !== l || ptr !== p || busy !== b) begin
      errors++;
      $display("FAIL async#%0d: got sel=%h level=%0d ptr=%0d busy=%b, want sel=%h level=%0d ptr=%0d busy=%b",
               id, sel, level, ptr, busy, s, l, p, b);
    end
  endtask

  // Monitor: after every rising edge, pop and compare entries due this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL sched#%0d: checked at cycle %0d, required cycle %0d", e.id, cyc, e.cyc);
        end else if (sel !== e.sel || level !== e.level || ptr !== e.ptr || busy !== e.busy) begin
          errors++;
          $display("FAIL chk#%0d: got sel=%h level=%0d ptr=%0d busy=%b, want sel=%h level=%0d ptr=%0d busy=%b",
                   e.id, sel, level, ptr, busy, e.sel, e.level, e.ptr, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle load pulse driven at a falling edge.
  task automatic drive(input logic [3:0] c, input logic [1:0] m);
    code_in = c; mode_in = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] th;
    rst_n = 1'b0; code_in = '0; mode_in = '0; load = 1'b0;
    #2;
    check_now(1, 16'h0000, 4'd0, 4'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Thermometer sweep with 10-cycle spacing; stability checked mid-gap.
    for (int k = 0; k < 16; k++) begin
      th = 16'((32'd1 << k) - 1);
      expect_at(1, 100 + k, th, 4'(k), 4'd0, 1'b0);
      expect_at(6, 200 + k, th, 4'(k), 4'd0, 1'b0);
      drive(4'(k), 2'b00);
      repeat (9) tick();
    end

    // One-hot.
    expect_at(1, 300, 16'h0020, 4'd5, 4'd0, 1'b0);
    drive(4'd5, 2'b01);
    expect_at(1, 301, 16'h0001, 4'd0, 4'd0, 1'b0);
    drive(4'd0, 2'b01);

    // DWA wrap, loads back to back.
    expect_at(1, 400, 16'h03FF, 4'd10, 4'd10, 1'b0);
    expect_at(2, 401, 16'hFC07, 4'd9,  4'd3,  1'b0);
    expect_at(3, 402, 16'h0000, 4'd0,  4'd3,  1'b0);
    expect_at(4, 403, 16'h0038, 4'd3,  4'd6,  1'b0);
    expect_at(8, 404, 16'h0038, 4'd3,  4'd6,  1'b0);
    drive(4'd10, 2'b10);
    drive(4'd9,  2'b10);
    drive(4'd0,  2'b10);
    drive(4'd3,  2'b10);
    repeat (6) tick();

    // Back to level 0, then ramp 0 -> 11 -> 2 with ignored loads while busy.
    expect_at(1, 500, 16'h0000, 4'd0, 4'd6, 1'b0);
    drive(4'd0, 2'b00);
    expect_at(1, 510, 16'h0000, 4'd0,  4'd6, 1'b1);
    expect_at(2, 511, 16'h0007, 4'd3,  4'd6, 1'b1);
    expect_at(3, 512, 16'h003F, 4'd6,  4'd6, 1'b1);
    expect_at(4, 513, 16'h01FF, 4'd9,  4'd6, 1'b1);
    expect_at(5, 514, 16'h07FF, 4'd11, 4'd6, 1'b0);
    expect_at(6, 520, 16'h07FF, 4'd11, 4'd6, 1'b1);
    expect_at(7, 521, 16'h00FF, 4'd8,  4'd6, 1'b1);
    expect_at(8, 522, 16'h001F, 4'd5,  4'd6, 1'b1);
    expect_at(9, 523, 16'h0003, 4'd2,  4'd6, 1'b0);
    expect_at(12, 524, 16'h0003, 4'd2, 4'd6, 1'b0);
    drive(4'd11, 2'b11);   // accepted
    drive(4'd2,  2'b11);   // ignored, busy
    tick();
    drive(4'd2,  2'b11);   // ignored, busy
    drive(4'd2,  2'b11);   // ignored, edge where busy clears
    drive(4'd2,  2'b11);   // accepted
    repeat (8) tick();

    // Reset mid-ramp 0 -> 15 at level 6.
    expect_at(1, 600, 16'h0000, 4'd0, 4'd6, 1'b0);
    drive(4'd0, 2'b00);
    expect_at(1, 601, 16'h0000, 4'd0, 4'd6, 1'b1);
    expect_at(2, 602, 16'h0007, 4'd3, 4'd6, 1'b1);
    expect_at(3, 603, 16'h003F, 4'd6, 4'd6, 1'b1);
    drive(4'd15, 2'b11);
    tick(); tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_now(604, 16'h0000, 4'd0, 4'd0, 1'b0);
    expect_at(1, 605, 16'h0000, 4'd0, 4'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_at(1, 606, 16'h000F, 4'd4, 4'd0, 1'b0);
    drive(4'd4, 2'b00);
    repeat (3) tick();

    // Mode interplay: ptr preserved across a thermometer load.
    expect_at(1, 700, 16'h007F, 4'd7, 4'd7, 1'b0);
    expect_at(2, 701, 16'h000F, 4'd4, 4'd7, 1'b0);
    expect_at(3, 702, 16'h0180, 4'd2, 4'd9, 1'b0);
    expect_at(6, 703, 16'h0180, 4'd2, 4'd9, 1'b0);
    drive(4'd7, 2'b10);
    drive(4'd4, 2'b00);
    drive(4'd2, 2'b10);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
